// File: rtl/led_pkg.sv
// Shared types and constants for the multiplexed 7-segment display blocks.
// Segment bit order is {dp,g,f,e,d,c,b,a}.
package led_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [7:0] seg_t;
  typedef logic [2:0] digit_idx_t;

  typedef struct packed {
    logic [31:0] nibbles;
    logic [7:0]  dp;
    logic [7:0]  blank;
  } disp_buf_t;

  // Hex glyphs in g..a; bit 7 (dp) is supplied separately
  localparam seg_t SEG_LUT [0:15] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  localparam seg_t SEG_OFF = 8'h00;

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Host/display signal bundle for the LED scan controller.
// master = host side that loads data, slave = the scan controller.
interface led_scan_ctrl_if;
  import led_pkg::*;

  logic        en;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  blank_in;
  digit_idx_t  cs_pointer;
  seg_t        seg;
  logic        frame_done;

  modport master (
    output en, load, data_in, dp_in, blank_in,
    input  cs_pointer, seg, frame_done
  );

  modport slave (
    input  en, load, data_in, dp_in, blank_in,
    output cs_pointer, seg, frame_done
  );

endinterface

// File: rtl/led_hex7seg.sv
// Combinational hex nibble + decimal point to active-high segment pattern.
module led_hex7seg
  import led_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output seg_t       seg
);

  seg_t glyph;

  assign glyph = SEG_LUT[nibble];
  assign seg   = {dp, glyph[6:0]};

endmodule

// File: rtl/led_scan_ctrl.sv
// 8-digit 7-segment scan controller: digit pointer, anti-ghost guard window
// and frame-synchronous double buffering of the displayed data.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  led_scan_ctrl_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] prescaler_reg, prescaler_next;
  digit_idx_t    ptr_reg, ptr_next;
  logic          frame_done_reg, frame_done_next;
  disp_buf_t     active_reg, active_next;
  disp_buf_t     pending_reg, pending_next;
  logic          pending_valid_reg, pending_valid_next;

  logic      tick;
  logic      wrap;
  disp_buf_t in_buf;

  assign in_buf = '{nibbles: bus.data_in, dp: bus.dp_in, blank: bus.blank_in};
  assign tick   = bus.en && (prescaler_reg == PRESCALE_LAST);
  assign wrap   = tick && (ptr_reg == digit_idx_t'(NUM_DIGITS - 1));

  always_comb begin
    prescaler_next     = prescaler_reg;
    ptr_next           = ptr_reg;
    frame_done_next    = wrap;
    active_next        = active_reg;
    pending_next       = pending_reg;
    pending_valid_next = pending_valid_reg;

    if (bus.en) begin
      prescaler_next = tick ? '0 : prescaler_reg + PW'(1);
    end
    if (tick) begin
      ptr_next = ptr_reg + digit_idx_t'(1);
    end

    // A load landing on the wrap edge bypasses the pending buffer entirely
    if (bus.load && wrap) begin
      active_next        = in_buf;
      pending_valid_next = 1'b0;
    end else if (bus.load) begin
      pending_next       = in_buf;
      pending_valid_next = 1'b1;
    end else if (wrap && pending_valid_reg) begin
      active_next        = pending_reg;
      pending_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_reg     <= '0;
      ptr_reg           <= '0;
      frame_done_reg    <= 1'b0;
      active_reg        <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
    end else begin
      prescaler_reg     <= prescaler_next;
      ptr_reg           <= ptr_next;
      frame_done_reg    <= frame_done_next;
      active_reg        <= active_next;
      pending_reg       <= pending_next;
      pending_valid_reg <= pending_valid_next;
    end
  end

  logic [3:0] nib_arr [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib_arr[gi] = active_reg.nibbles[4*gi +: 4];
  end

  seg_t dec_seg;

  led_hex7seg u_hex (
    .nibble (nib_arr[ptr_reg]),
    .dp     (active_reg.dp[ptr_reg]),
    .seg    (dec_seg)
  );

  logic in_guard;

  if (GUARD == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    localparam logic [PW-1:0] GUARD_V = PW'(GUARD);
    assign in_guard = (prescaler_reg < GUARD_V);
  end

  seg_t seg_raw;

  // rst_n gates the output so the display goes dark the instant reset asserts
  always_comb begin
    seg_raw = SEG_OFF;
    if (rst_n && bus.en && !in_guard && !active_reg.blank[ptr_reg]) begin
      seg_raw = dec_seg;
    end
  end

  assign bus.seg        = seg_raw ^ {8{SEG_ACTIVE_LOW}};
  assign bus.cs_pointer = ptr_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
Scan controller for the 8-digit multiplexed 7-segment LED display. It generates the 3-bit digit pointer that drives the downstream chip-select decoder. It also produces the segment pattern for the currently selected digit. Display data is double-buffered: host writes land in a pending buffer and take effect only at a frame boundary, so a frame never shows torn data.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays selected; legal range 2..2^20.
GUARD, 500, cycles at the start of each digit slot during which segments are forced off (anti-ghosting); legal range 0..SCAN_DIV-1.
SEG_ACTIVE_LOW, 0, 1 inverts all seg bits at the output.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
en  input  1  scan enable; 0 freezes scanning and blanks the segments
load  input  1  single-cycle write strobe for data_in/dp_in/blank_in
data_in  input  32  eight hex nibbles; nibble k (bits 4k+3:4k) is shown on digit k
dp_in  input  8  decimal point for each digit
blank_in  input  8  1 = digit k fully dark
cs_pointer  output  3  registered index of the selected digit, to the chip-select decoder
seg  output  8  {dp,g,f,e,d,c,b,a}; segment pattern for digit cs_pointer
frame_done  output  1  one-cycle pulse when the pointer wraps from 7 to 0

Behaviour:
- Reset (async assert, sync release): prescaler=0, cs_pointer=0, active and pending buffers=0, pending_valid=0, frame_done=0. seg is in the off state (0x00, or 0xFF when SEG_ACTIVE_LOW=1) immediately, with no clock needed.
- Prescaler: counts 0..SCAN_DIV-1 while en=1. tick = (prescaler==SCAN_DIV-1) && en. On tick the prescaler returns to 0.
- On tick: cs_pointer <= cs_pointer+1, wrapping 7->0. wrap = tick && cs_pointer==7.
- frame_done: registered, equal to 1 for exactly the cycle after the wrap edge, i.e. aligned with cs_pointer==0.
- Buffers:
  - load=1 with no wrap in the same cycle: pending <= inputs, pending_valid <= 1. Multiple loads within one frame: the last one wins.
  - wrap with no load: if pending_valid=1, then active <= pending and pending_valid <= 0.
  - load and wrap in the same cycle: active <= inputs directly, pending_valid <= 0. Any older pending data is discarded.
- seg: combinational from registered state only (cs_pointer, prescaler, active buffer, en).
  - Forced off when en=0, or when prescaler < GUARD, or when active.blank[cs_pointer]=1.
  - Otherwise seg = {active.dp[cs_pointer], HEX7(active.nibble[cs_pointer])}.
  - Because active and cs_pointer update on the same edge, the new frame's data appears together with digit 0.
- HEX7 (g..a): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- SEG_ACTIVE_LOW: a final XOR on all 8 bits, including the off state.
- en 1->0: prescaler and cs_pointer hold their values. load is still accepted. A wrap cannot occur while en=0. en 0->1: counting resumes from the held values.
- Latency: a load takes effect at the next wrap. Worst case 8*SCAN_DIV cycles; best case 0 extra (load coincident with wrap).

Decomposition:
- Package led_pkg:
  - NUM_DIGITS=8
  - typedef seg_t (logic [7:0])
  - typedef digit_idx_t (logic [2:0])
  - packed struct disp_buf_t {nibbles[31:0], dp[7:0], blank[7:0]}
  - constant SEG_LUT[16] of seg_t (the HEX7 table)
  - SEG_OFF=8'h00
- Sub-module led_hex7seg: purely combinational nibble+dp -> seg_t via SEG_LUT. It is reused by other display blocks.

Test Plan:
1. SCAN_DIV=4, GUARD=1, reset, en=1 -> cs_pointer steps 0,1,..,7 every 4 clks and wraps to 0 after 32 clks. frame_done is high for exactly 1 clk every 32 clks, coincident with pointer 0.
2. Mid-frame load data_in=0x76543210, dp_in=0x00, blank_in=0x00 -> seg unchanged until wrap. After wrap: pointer0 seg=0x3F, pointer1 0x06, pointer5 0x6D, pointer7 0x07.
3. GUARD check -> seg=0x00 on the first clk of every digit slot and the decoded value on the remaining 3. With GUARD=0 there is no blank cycle.
4. load 0x11111111 then 0xFFFFFFFF in the same frame -> next frame shows 0x71 on all digits. A load on the exact wrap cycle shows its data on digit 0 of that same new frame.
5. en=0 at pointer 3 -> pointer holds at 3 and seg=0x00 for the whole en=0 interval. After en=1, 3->4 occurs after the remaining prescaler count. dp_in=0x01, blank_in=0x80 -> digit0 has bit7 set, digit7 seg=0x00.
6. Assert rst_n=0 mid-slot with SEG_ACTIVE_LOW=1 -> seg=0xFF, cs_pointer=0, frame_done=0 before any clk edge. After release, an old pending load is lost and the display shows all '0' (0xC0 active-low) except where blanked.
